// File: rtl/pc_stack_pkg.sv
// Shared sequencing-op encoding for the decoder and the pc/stack unit.
// Also holds small helpers for classifying ops.
package pc_stack_pkg;

    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NEXT   = 3'd0,
        OP_SKIP   = 3'd1,
        OP_GOTO   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RETURN = 3'd4,
        OP_INT    = 3'd5
    } op_t;

    function automatic logic is_push(
        input logic [OP_WIDTH-1:0] op
    );
        return (op == OP_CALL) || (op == OP_INT);
    endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Decoder-side bundle of the pc/stack unit.
// The decoder drives op and jump fields; the unit returns pc and stack status.
interface pc_stack_unit_if #(
    parameter int PC_WIDTH    = 13,
    parameter int JUMP_WIDTH  = 11,
    parameter int STACK_DEPTH = 8
);
    localparam int DW = $clog2(STACK_DEPTH) + 1;

    logic                         stall;
    logic [2:0]                   op;
    logic [JUMP_WIDTH-1:0]        target;
    logic [PC_WIDTH-JUMP_WIDTH-1:0] page_sel;
    logic                         err_clear;
    logic [PC_WIDTH-1:0]          pc;
    logic [DW-1:0]                depth;
    logic                         stack_full;
    logic                         stack_empty;
    logic                         overflow_err;
    logic                         underflow_err;

    modport master (
        output stall, op, target, page_sel, err_clear,
        input  pc, depth, stack_full, stack_empty,
        input  overflow_err, underflow_err
    );

    modport slave (
        input  stall, op, target, page_sel, err_clear,
        output pc, depth, stack_full, stack_empty,
        output overflow_err, underflow_err
    );

endinterface

// File: rtl/pc_stack_unit_call_stack.sv
// LIFO return-address storage with wrapping top pointer and depth counter.
// Top-of-stack read is combinational for zero-latency returns.
module call_stack #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8,
    parameter bit WRAP  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top;
    logic             wr_en;
    logic             rd_en;

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);
    // When full, top already points at the oldest slot, so wrap overwrites it.
    assign wr_en = push && (!full || WRAP);
    assign rd_en = pop && !empty && !push;
    assign rdata = mem[top - PW'(1)];

    always_ff @(posedge clk) begin
        if (wr_en) mem[top] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top   <= '0;
            depth <= '0;
        end else if (wr_en) begin
            top <= top + PW'(1);
            if (!full) depth <= depth + DW'(1);
        end else if (rd_en) begin
            top   <= top - PW'(1);
            depth <= depth - DW'(1);
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program-counter sequencer: next-pc mux, call stack and sticky
// overflow/underflow flags for the 14-bit-instruction core.
module pc_stack_unit
    import pc_stack_pkg::*;
#(
    parameter int PC_WIDTH    = 13,
    parameter int JUMP_WIDTH  = 11,
    parameter int STACK_DEPTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0] INT_VECTOR   = PC_WIDTH'(4),
    parameter bit OVF_WRAP    = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    pc_stack_unit_if.slave bus
);
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] jump_pc;
    logic [PC_WIDTH-1:0] push_data;
    logic [PC_WIDTH-1:0] top_data;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                ovf_set;
    logic                unf_set;
    logic                ovf_q;
    logic                unf_q;

    assign pc_inc  = pc_q + PC_WIDTH'(1);
    assign jump_pc = {bus.page_sel, bus.target};
    assign push    = !bus.stall && is_push(bus.op);
    assign ovf_set = push && full;

    always_comb begin
        pc_d      = pc_inc;
        push_data = pc_inc;
        pop       = 1'b0;
        unf_set   = 1'b0;
        case (bus.op)
            OP_SKIP: pc_d = pc_q + PC_WIDTH'(2);
            OP_GOTO: pc_d = jump_pc;
            OP_CALL: pc_d = jump_pc;
            OP_RETURN: begin
                if (empty) begin
                    unf_set = !bus.stall;
                end else begin
                    pop  = !bus.stall;
                    pc_d = top_data;
                end
            end
            // Interrupted instruction re-executes on return.
            OP_INT: begin
                push_data = pc_q;
                pc_d      = INT_VECTOR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_q  <= pc_d;
            ovf_q <= ovf_set || (ovf_q && !bus.err_clear);
            unf_q <= unf_set || (unf_q && !bus.err_clear);
        end
    end

    call_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH),
        .WRAP  (OVF_WRAP)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (push_data),
        .rdata (top_data),
        .depth (bus.depth),
        .full  (full),
        .empty (empty)
    );

    assign bus.pc            = pc_q;
    assign bus.stack_full    = full;
    assign bus.stack_empty   = empty;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench: wrap and no-wrap units share stimulus, each
// checked against a list-based model of pc, return stack and flags.
module tb_pc_stack_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pc_stack_unit_if ifw ();
    pc_stack_unit_if ifn ();

    pc_stack_unit #(.OVF_WRAP(1'b1)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (ifw)
    );

    pc_stack_unit #(.OVF_WRAP(1'b0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (ifn)
    );

    typedef struct {
        int pc;
        int dep;
        int ovf;
        int unf;
    } exp_t;

    exp_t qw[$];
    exp_t qn[$];

    int n_pass = 0;
    int n_total = 0;

    int mpc[2];
    int cnt[2];
    int stk[2][8];
    int movf[2];
    int munf[2];

    task automatic chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mpc[m] = 0;
            cnt[m] = 0;
            movf[m] = 0;
            munf[m] = 0;
        end
    endtask

    task automatic model_push(int m, int v, output int ov);
        ov = 0;
        if (cnt[m] < 8) begin
            stk[m][cnt[m]] = v;
            cnt[m]++;
        end else begin
            ov = 1;
            if (m == 0) begin
                for (int i = 0; i < 7; i++) stk[m][i] = stk[m][i+1];
                stk[m][7] = v;
            end
        end
    endtask

    task automatic model_step(int m, int op, int tgt, int pg,
                              bit st, bit clr);
        int nxt;
        int ovs;
        int uns;
        if (st) return;
        nxt = (mpc[m] + 1) % 8192;
        ovs = 0;
        uns = 0;
        case (op)
            1: mpc[m] = (mpc[m] + 2) % 8192;
            2: mpc[m] = pg * 2048 + tgt;
            3: begin
                model_push(m, nxt, ovs);
                mpc[m] = pg * 2048 + tgt;
            end
            4: begin
                if (cnt[m] == 0) begin
                    uns = 1;
                    mpc[m] = nxt;
                end else begin
                    cnt[m]--;
                    mpc[m] = stk[m][cnt[m]];
                end
            end
            5: begin
                model_push(m, mpc[m], ovs);
                mpc[m] = 4;
            end
            default: mpc[m] = nxt;
        endcase
        movf[m] = (ovs != 0 || (movf[m] != 0 && !clr)) ? 1 : 0;
        munf[m] = (uns != 0 || (munf[m] != 0 && !clr)) ? 1 : 0;
    endtask

    task automatic step(int op, int tgt = 0, int pg = 0,
                        bit st = 1'b0, bit clr = 1'b0);
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        ifw.op = 3'(op);
        ifn.op = 3'(op);
        ifw.target = 11'(tgt);
        ifn.target = 11'(tgt);
        ifw.page_sel = 2'(pg);
        ifn.page_sel = 2'(pg);
        ifw.stall = st;
        ifn.stall = st;
        ifw.err_clear = clr;
        ifn.err_clear = clr;
        for (int m = 0; m < 2; m++) begin
            model_step(m, op, tgt, pg, st, clr);
            e.pc = mpc[m];
            e.dep = cnt[m];
            e.ovf = movf[m];
            e.unf = munf[m];
            if (m == 0) qw.push_back(e);
            else qn.push_back(e);
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_pc_w", int'(ifw.pc), 0);
        chk("rst_dep_w", int'(ifw.depth), 0);
        chk("rst_empty_w", int'(ifw.stack_empty), 1);
        chk("rst_full_w", int'(ifw.stack_full), 0);
        chk("rst_ovf_w", int'(ifw.overflow_err), 0);
        chk("rst_unf_w", int'(ifw.underflow_err), 0);
        chk("rst_pc_n", int'(ifn.pc), 0);
        chk("rst_ovf_n", int'(ifn.overflow_err), 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qw.size() > 0) begin
            e = qw.pop_front();
            chk("pc_w", int'(ifw.pc), e.pc);
            chk("depth_w", int'(ifw.depth), e.dep);
            chk("full_w", int'(ifw.stack_full), int'(e.dep == 8));
            chk("empty_w", int'(ifw.stack_empty), int'(e.dep == 0));
            chk("ovf_w", int'(ifw.overflow_err), e.ovf);
            chk("unf_w", int'(ifw.underflow_err), e.unf);
        end
        if (qn.size() > 0) begin
            e = qn.pop_front();
            chk("pc_n", int'(ifn.pc), e.pc);
            chk("depth_n", int'(ifn.depth), e.dep);
            chk("full_n", int'(ifn.stack_full), int'(e.dep == 8));
            chk("empty_n", int'(ifn.stack_empty), int'(e.dep == 0));
            chk("ovf_n", int'(ifn.overflow_err), e.ovf);
            chk("unf_n", int'(ifn.underflow_err), e.unf);
        end
    end

    initial begin
        ifw.stall = 1'b1;
        ifn.stall = 1'b1;
        ifw.op = 3'd0;
        ifn.op = 3'd0;
        ifw.target = '0;
        ifn.target = '0;
        ifw.page_sel = '0;
        ifn.page_sel = '0;
        ifw.err_clear = 1'b0;
        ifn.err_clear = 1'b0;
        model_reset();

        // async reset mid-run
        repeat (5) step(0);
        mid_reset();

        // call/return across pages
        step(2, 'h010, 0);
        step(3, 'h123, 1);
        step(4);

        // nested calls past full, then unwind past empty
        for (int i = 0; i < 9; i++) step(3, 'h100 + 16 * i, i % 4);
        for (int i = 0; i < 9; i++) step(4);
        mid_reset();

        // pc wrap
        step(2, 'h7FF, 3);
        step(0);
        step(2, 'h7FE, 3);
        step(1);
        step(2, 'h7FF, 3);
        step(1);

        // interrupt under stall, then return
        step(2, 'h050, 0);
        step(5, 0, 0, 1'b1);
        step(5, 0, 0, 1'b1);
        step(5);
        step(4);
        step(4);
        step(4, 0, 0, 1'b0, 1'b1);
        step(0, 0, 0, 1'b1, 1'b1);
        step(0, 0, 0, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 2047)),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0));
        end

        @(posedge clk);
        #3;
        chk("drain_w", qw.size(), 0);
        chk("drain_n", qn.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
